// File: rtl/pcihellocore_pio_pkg.sv
// Shared constants for the PCI hello core PIO blocks: register map, edge
// encodings and a counter-width helper.
package pcihellocore_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Width of a 0..cycles-1 counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pcihellocore_debounce.sv
// Two-flop synchronizer followed by a tick-sampled debouncer; a level must be
// seen on two consecutive ticks before it reaches db_o.
module pcihellocore_debounce
  import pcihellocore_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic [DATA_WIDTH-1:0] db_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] s1_q, s2_q;
  logic [DATA_WIDTH-1:0] samp_q, samp_d;
  logic [DATA_WIDTH-1:0] db_q, db_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  tick;
  logic [DATA_WIDTH-1:0] differ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    tick  = (cnt_q == CntLast);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Bits whose synchronized level matches the previous tick's sample are
  // accepted; the rest keep their debounced value.
  always_comb begin
    differ = s2_q ^ samp_q;
    samp_d = samp_q;
    db_d   = db_q;
    if (tick) begin
      samp_d = s2_q;
      db_d   = (s2_q & ~differ) | (db_q & differ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      samp_q <= '0;
      db_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      samp_q <= samp_d;
      db_q   <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/pcihellocore_pio_in.sv
// Avalon-MM input PIO: debounced input lines with edge capture, per-bit
// interrupt mask and a level interrupt.
module pcihellocore_pio_in
  import pcihellocore_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] db;
  logic [DATA_WIDTH-1:0] db_prev_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] clr;
  logic [31:0]           readdata_q, readdata_d;
  logic [31:0]           rd_mux;
  logic                  wr_en, rd_en;

  pcihellocore_debounce #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .in_i   (in_port),
    .db_o   (db)
  );

  if (DATA_WIDTH < 32) begin : g_wd_pad
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[31:DATA_WIDTH];
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = ~db & db_prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = db ^ db_prev_q;
    end else begin
      edge_det = db & ~db_prev_q;
    end
  end

  always_comb begin
    wr_en = chipselect & ~write_n;
    rd_en = chipselect & write_n;

    irqmask_d = irqmask_q;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[DATA_WIDTH-1:0];
    end

    // Set is applied after clear so a same-cycle edge survives the write.
    clr = '0;
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clr = writedata[DATA_WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr) | edge_det;

    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = db;
      ADDR_IRQMASK: rd_mux[DATA_WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rd_mux[DATA_WIDTH-1:0] = edgecap_q;
      default:      rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev_q  <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      db_prev_q  <= db;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pcihellocore_pio_in.sv
// Directed self-checking bench for pcihellocore_pio_in (18 lines, tick every 4
// cycles, rising-edge capture).
module tb_pcihellocore_pio_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [17:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks;
  int failures;
  int cyc;

  pcihellocore_pio_in #(
    .DATA_WIDTH      (18),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release; debounce ticks land on multiples of 4.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_readdata got=%h want=%h", readdata, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b want=0", irq);
    end
    reset_n = 1'b1;
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_irqmask got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_edgecap got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    in_port = 18'h00008;
    @(negedge clk);
    in_port = 18'h00000;
    repeat (20) @(negedge clk);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_data got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_edgecap got=%h want=%h", d, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL glitch_irq got=%b want=0", irq);
    end
  endtask

  task automatic test_data();
    logic [31:0] d;
    in_port = 18'h2A5A5;
    repeat (20) @(negedge clk);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0002A5A5) begin
      failures++;
      $display("FAIL data_value got=%h want=%h", d, 32'h0002A5A5);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL data_rsvd got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0002A5A5) begin
      failures++;
      $display("FAIL data_rise_cap got=%h want=%h", d, 32'h0002A5A5);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL data_irq_masked got=%b want=0", irq);
    end
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd3, 32'h0003FFFF);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0002A5A5) begin
      failures++;
      $display("FAIL data_ro got=%h want=%h", d, 32'h0002A5A5);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL data_clear_all got=%h want=%h", d, 32'h0);
    end
    in_port = 18'h00000;
    repeat (20) @(negedge clk);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL data_fall_value got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL data_fall_nocap got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    bus_write(2'd2, 32'h00000001);
    in_port = 18'h00001;
    repeat (20) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h00000001) begin
      failures++;
      $display("FAIL edge_cap got=%h want=%h", d, 32'h1);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL edge_irq_set got=%b want=1", irq);
    end
    bus_write(2'd3, 32'h00000001);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL edge_irq_clear got=%b want=0", irq);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL edge_cap_clear got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    bus_write(2'd2, 32'h00000000);
    in_port = 18'h00021;
    repeat (20) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h00000020) begin
      failures++;
      $display("FAIL mask_cap got=%h want=%h", d, 32'h20);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL mask_irq_off got=%b want=0", irq);
    end
    bus_write(2'd2, 32'hFFFC0020);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL mask_irq_on got=%b want=1", irq);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h00000020) begin
      failures++;
      $display("FAIL mask_readback got=%h want=%h", d, 32'h20);
    end
  endtask

  // in_port[2] rises before posedge c+1 (c%4==1): sampled on tick c+3,
  // accepted on tick c+7, captured at posedge c+8 together with the clear.
  task automatic test_simul_clear();
    logic [31:0] d;
    @(negedge clk);
    while (cyc % 4 != 1) @(negedge clk);
    in_port = 18'h00025;
    repeat (7) @(negedge clk);
    address    = 2'd3;
    writedata  = 32'h00000024;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h00000004) begin
      failures++;
      $display("FAIL simul_set_wins got=%h want=%h", d, 32'h4);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL simul_irq got=%b want=0", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(2'd2, 32'h0003FFFF);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_irq_pre got=%b want=1", irq);
    end
    in_port = 18'h3FFFF;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_irq got=%b want=0", irq);
    end
    in_port = 18'h00000;
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_data got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_irqmask got=%h want=%h", d, 32'h0);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_edgecap got=%h want=%h", d, 32'h0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 18'h0;
    test_reset();
    test_glitch();
    test_data();
    test_edge_irq();
    test_mask();
    test_simul_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
